// File: rtl/imem_pipe.sv
// Instruction memory with a program write port and a 1- or 2-stage read pipeline.
// Requests and responses use valid/ready; the whole pipeline freezes while a response is refused.
module imem_pipe #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [ADDR_W-1:0]        i_req_addr,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [31:0]              o_rsp_data,
    output logic [1:0]               o_rsp_err,
    input  logic                     i_prog_en,
    input  logic [$clog2(DEPTH)-1:0] i_prog_addr,
    input  logic [31:0]              i_prog_data,
    output logic [31:0]              o_fetch_cnt
);
    // Handshake: a request transfers when i_req_valid && o_req_ready; a response
    // transfers when o_rsp_valid && i_rsp_ready and is held unchanged until then.
    localparam int AW = $clog2(DEPTH);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-3:0] word_idx;
    logic              advance;
    logic              accept;
    logic [31:0]       rd_data;
    logic [1:0]        rd_err;
    logic              head_valid;
    logic [31:0]       head_data;
    logic [1:0]        head_err;
    logic [31:0]       fetch_cnt;

    assign word_idx    = i_req_addr[ADDR_W-1:2];
    assign advance     = !o_rsp_valid || i_rsp_ready;
    assign o_req_ready = advance && !i_prog_en && !i_rst;
    assign accept      = i_req_valid && o_req_ready;
    assign o_fetch_cnt = fetch_cnt;

    // Misalignment wins over range; erroring requests never touch the array.
    always_comb begin
        rd_data = '0;
        rd_err  = 2'b00;
        if (i_req_addr[1:0] != 2'b00) begin
            rd_err = 2'b01;
        end else if (word_idx[ADDR_W-3:AW] != '0) begin
            rd_err = 2'b10;
        end else begin
            rd_data = mem[word_idx[AW-1:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_prog_en && !i_rst) begin
            mem[i_prog_addr] <= i_prog_data;
        end
    end

    generate
        if (LATENCY == 2) begin : g_two_stage
            logic        s1_valid;
            logic [31:0] s1_data;
            logic [1:0]  s1_err;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    s1_err   <= 2'b00;
                end else if (advance) begin
                    s1_valid <= accept;
                    s1_data  <= rd_data;
                    s1_err   <= rd_err;
                end
            end

            assign head_valid = s1_valid;
            assign head_data  = s1_data;
            assign head_err   = s1_err;
        end else begin : g_one_stage
            assign head_valid = accept;
            assign head_data  = rd_data;
            assign head_err   = rd_err;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 2'b00;
        end else if (advance) begin
            o_rsp_valid <= head_valid;
            o_rsp_data  <= head_valid ? head_data : 32'h0;
            o_rsp_err   <= head_valid ? head_err  : 2'b00;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_cnt <= '0;
        end else if (accept && fetch_cnt != 32'hFFFF_FFFF) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_imem_pipe.sv
// Bench for imem_pipe: a LATENCY=1 and a LATENCY=2 instance share one stimulus stream,
// each tracked by its own scoreboard and counter model, plus directed corner sequences.
module tb_imem_pipe;
  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        prog_en;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;

  logic        rdy [2];
  logic        rv [2];
  logic [31:0] rd [2];
  logic [1:0]  re [2];
  logic [31:0] cnt [2];

  imem_pipe #(.DEPTH(64), .LATENCY(1), .ADDR_W(32)) u1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy[0]),
    .i_req_addr(req_addr), .o_rsp_valid(rv[0]), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rd[0]), .o_rsp_err(re[0]), .i_prog_en(prog_en),
    .i_prog_addr(prog_addr), .i_prog_data(prog_data), .o_fetch_cnt(cnt[0])
  );

  imem_pipe #(.DEPTH(64), .LATENCY(2), .ADDR_W(32)) u2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(rdy[1]),
    .i_req_addr(req_addr), .o_rsp_valid(rv[1]), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rd[1]), .o_rsp_err(re[1]), .i_prog_en(prog_en),
    .i_prog_addr(prog_addr), .i_prog_data(prog_data), .o_fetch_cnt(cnt[1])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;

  // reference model state
  logic [31:0] model_mem [64];
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  logic [31:0] cnt_m [2];
  bit          held [2];
  logic [34:0] held_v [2];
  bit          exp_idle [2];
  bit          sb_on = 1'b0;
  bit          load_cnt = 1'b0;
  logic [31:0] load_val = 32'h0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  err;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] model_rsp(input logic [31:0] a);
    if (a[1:0] != 2'b00) return {2'b01, 32'h0};
    if ((a >> 2) >= 32'd64) return {2'b10, 32'h0};
    return {2'b00, model_mem[a[7:2]]};
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [33:0] q_pop(input int k);
    if (k == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic void q_push(input int k, input logic [33:0] v);
    if (k == 0) exp_q0.push_back(v);
    else exp_q1.push_back(v);
  endfunction

  function automatic void q_clear(input int k);
    if (k == 0) exp_q0.delete();
    else exp_q1.delete();
  endfunction

  // scoreboard: runs once per cycle, after inputs settle and before the rising edge
  task automatic sample();
    logic [33:0] e;
    for (int k = 0; k < 2; k++) begin
      if (k == 0 && load_cnt) cnt_m[0] = load_val;
      if (sb_on) begin
        if (exp_idle[k]) begin
          chk("rst_idle", {rv[k], re[k], rd[k]}, 35'h0);
        end
        if (held[k]) begin
          chk("hold_stable", {rv[k], re[k], rd[k]}, held_v[k]);
        end
        chk("fetch_cnt", {32'h0, cnt[k]}, {32'h0, cnt_m[k]});
        if (rst) chk("ready_in_rst", {63'h0, rdy[k]}, 64'h0);
        else chk("ready_rule", {63'h0, rdy[k]}, {63'h0, (!rv[k] || rsp_ready) && !prog_en});
        if (rv[k] && rsp_ready && !rst) begin
          if (q_size(k) == 0) begin
            chk("unexpected_rsp", {63'h0, rv[k]}, 64'h0);
          end else begin
            e = q_pop(k);
            chk("rsp_value", {30'h0, re[k], rd[k]}, {30'h0, e});
          end
        end
      end
      exp_idle[k] = 1'b0;
      held[k] = rv[k] && !rsp_ready && !rst;
      held_v[k] = {rv[k], re[k], rd[k]};
      if (req_valid && rdy[k] && !rst) begin
        q_push(k, model_rsp(req_addr));
        if (cnt_m[k] != 32'hFFFF_FFFF) cnt_m[k] = cnt_m[k] + 32'd1;
      end
      if (rst) begin
        q_clear(k);
        cnt_m[k] = 32'h0;
        exp_idle[k] = 1'b1;
        held[k] = 1'b0;
      end
    end
    if (prog_en && !rst) model_mem[prog_addr] = prog_data;
  endtask

  // ends the current cycle; returns at the next falling edge
  task automatic tick();
    #2;
    sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_addr = 32'h0;
    prog_en = 1'b0;
    prog_addr = 6'h0;
    prog_data = 32'h0;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [31:0] w;
    for (int k = 0; k < 2; k++) begin
      cnt_m[k] = 32'h0;
      held[k] = 1'b0;
      exp_idle[k] = 1'b0;
    end
    idle_inputs();
    rsp_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    tick();
    sb_on = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_valid_u1", {63'h0, rv[0]}, 64'h0);
    chk("reset_cnt_u2", {32'h0, cnt[1]}, 64'h0);

    // program every word so the model knows the whole array
    for (int i = 0; i < 64; i++) begin
      prog_en = 1'b1;
      prog_addr = 6'(i);
      w = $urandom;
      if (i == 0) w = 32'h00A0_0593;
      if (i == 1) w = 32'h0005_8073;
      if (i == 63) w = 32'h1234_5678;
      prog_data = w;
      tick();
    end
    idle_inputs();
    tick();

    // table: back-to-back fetches with an always-ready consumer
    vecs[0] = '{32'h0000_0000, 32'h00A0_0593, 2'b00};
    vecs[1] = '{32'h0000_0004, 32'h0005_8073, 2'b00};
    vecs[2] = '{32'h0000_0002, 32'h0000_0000, 2'b01};
    vecs[3] = '{32'h0000_0100, 32'h0000_0000, 2'b10};
    vecs[4] = '{32'h0000_00FC, 32'h1234_5678, 2'b00};
    vecs[5] = '{32'h0000_0103, 32'h0000_0000, 2'b01};
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_addr = vecs[i].addr;
      #1;
      chk("vec_ready", {63'h0, rdy[0]}, 64'h1);
      tick();
      chk("vec_l1_rsp", {29'h0, rv[0], re[0], rd[0]}, {29'h0, 1'b1, vecs[i].err, vecs[i].data});
      chk("vec_l1_cnt", {32'h0, cnt[0]}, 64'(i + 1));
      if (i > 0) chk("vec_l2_rsp", {29'h0, rv[1], re[1], rd[1]}, {29'h0, 1'b1, vecs[i-1].err, vecs[i-1].data});
    end
    idle_inputs();
    tick();
    chk("vec_l2_last", {29'h0, rv[1], re[1], rd[1]}, {29'h0, 1'b1, vecs[5].err, vecs[5].data});
    drain(3);

    // randomized traffic with backpressure and interleaved programming
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0, 1: req_addr = 32'($urandom_range(0, 63)) << 2;
        2: req_addr = (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
        default: req_addr = $urandom;
      endcase
      rsp_ready = ($urandom_range(0, 3) != 0);
      prog_en = ($urandom_range(0, 7) == 0);
      prog_addr = 6'($urandom_range(8, 63));
      prog_data = $urandom;
      tick();
    end
    drain(5);
    chk("drain_q0", 64'(exp_q0.size()), 64'h0);
    chk("drain_q1", 64'(exp_q1.size()), 64'h0);

    // LATENCY=2 stall: three requests, consumer refuses for four cycles
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    req_addr = 32'h0;
    #1;
    chk("stall_c0_ready", {63'h0, rdy[1]}, 64'h1);
    tick();
    req_addr = 32'h4;
    #1;
    chk("stall_c1_ready", {63'h0, rdy[1]}, 64'h1);
    tick();
    req_addr = 32'h8;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("stall_ready_low", {63'h0, rdy[1]}, 64'h0);
      chk("stall_first_held", {31'h0, rv[1], rd[1]}, {31'h0, 1'b1, 32'h00A0_0593});
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("stall_release_ready", {63'h0, rdy[1]}, 64'h1);
    chk("stall_rsp0", {31'h0, rv[1], rd[1]}, {31'h0, 1'b1, 32'h00A0_0593});
    tick();
    req_valid = 1'b0;
    chk("stall_rsp1", {31'h0, rv[1], rd[1]}, {31'h0, 1'b1, 32'h0005_8073});
    tick();
    chk("stall_rsp2", {31'h0, rv[1], rd[1]}, {31'h0, 1'b1, model_mem[2]});
    drain(3);

    // program write collides with a pending request
    req_valid = 1'b1;
    req_addr = 32'h14;
    prog_en = 1'b1;
    prog_addr = 6'd5;
    prog_data = 32'hDEAD_BEEF;
    #1;
    chk("write_blocks_u1", {63'h0, rdy[0]}, 64'h0);
    chk("write_blocks_u2", {63'h0, rdy[1]}, 64'h0);
    tick();
    prog_en = 1'b0;
    #1;
    chk("after_write_ready", {63'h0, rdy[0]}, 64'h1);
    tick();
    req_valid = 1'b0;
    chk("new_data_u1", {30'h0, re[0], rd[0]}, {30'h0, 2'b00, 32'hDEAD_BEEF});
    tick();
    chk("new_data_u2", {30'h0, re[1], rd[1]}, {30'h0, 2'b00, 32'hDEAD_BEEF});
    drain(3);

    // reset with two requests in flight; a write during reset is ignored
    req_valid = 1'b1;
    req_addr = 32'h0;
    tick();
    req_addr = 32'h4;
    tick();
    idle_inputs();
    rst = 1'b1;
    prog_en = 1'b1;
    prog_addr = 6'd1;
    prog_data = 32'hFFFF_FFFF;
    #1;
    chk("rst_ready_u1", {63'h0, rdy[0]}, 64'h0);
    tick();
    rst = 1'b0;
    prog_en = 1'b0;
    chk("rst_valid_u1", {63'h0, rv[0]}, 64'h0);
    chk("rst_valid_u2", {63'h0, rv[1]}, 64'h0);
    chk("rst_cnt_u1", {32'h0, cnt[0]}, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_stale_u1", {63'h0, rv[0]}, 64'h0);
      chk("no_stale_u2", {63'h0, rv[1]}, 64'h0);
    end
    req_valid = 1'b1;
    req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    chk("mem_kept_u1", {31'h0, rv[0], rd[0]}, {31'h0, 1'b1, 32'h0005_8073});
    drain(3);

    // counter saturation
    load_cnt = 1'b1;
    load_val = 32'hFFFF_FFFE;
    force u1.fetch_cnt = 32'hFFFF_FFFE;
    #1;
    release u1.fetch_cnt;
    tick();
    load_cnt = 1'b0;
    req_valid = 1'b1;
    req_addr = 32'h0;
    for (int i = 0; i < 3; i++) tick();
    req_valid = 1'b0;
    chk("cnt_saturate", {32'h0, cnt[0]}, {32'h0, 32'hFFFF_FFFF});
    drain(3);
    chk("final_q0", 64'(exp_q0.size()), 64'h0);
    chk("final_q1", 64'(exp_q1.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
